// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one shared multi-cycle ALU to N_REQ requesters.
// Latency: capture -> ISSUE -> WAIT (>=1 cycle) -> RESP, so at least 4 edges from capture to return to IDLE.
// Backpressure: one request in flight; req_ready pulses once per grant and other requesters hold req_valid.
module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [6*N_REQ-1:0]         req_op,
    input  logic [DATA_W*N_REQ-1:0]    req_a,
    input  logic [DATA_W*N_REQ-1:0]    req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       alu_start,
    output logic [5:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_done,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  winner;
    logic [TW-1:0]   timer;

    logic            found;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    int              idx;

    logic            op_legal;
    logic            timer_last;

    assign op_legal   = (alu_op >= 6'h01) && (alu_op <= 6'h0B);
    assign timer_last = (timer == TW'(TIMEOUT - 1));

    // Rotating priority search: first valid index strictly after last_grant, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an illegal opcode skips the ALU and goes straight to the error response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = op_legal ? WAIT : RESP;
            WAIT:    if (alu_done || timer_last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, wait timer and response registers; alu_done beats the timeout in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(N_REQ - 1);
            winner     <= '0;
            timer      <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner   <= pick;
                        alu_op   <= req_op[6*int'(pick) +: 6];
                        alu_a    <= req_a[DATA_W*int'(pick) +: DATA_W];
                        alu_b    <= req_b[DATA_W*int'(pick) +: DATA_W];
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    if (!op_legal) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (alu_done) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                    end else if (timer_last) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= winner;
                end
                default: ;
            endcase
        end
    end

    // Strobes are pure state decodes so reset clears them immediately.
    always_comb begin
        req_ready = '0;
        if (state == ISSUE) begin
            req_ready[winner] = 1'b1;
        end
        alu_start = (state == ISSUE) && op_legal;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        rsp_id    = winner;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with the shared ALU played by the stimulus itself.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters drop req_valid after their grant unless a test holds them on purpose.
module tb_alu_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                     clk;
    logic                     rst_n;
    logic [N_REQ-1:0]         req_valid;
    logic [6*N_REQ-1:0]       req_op;
    logic [DATA_W*N_REQ-1:0]  req_a;
    logic [DATA_W*N_REQ-1:0]  req_b;
    logic [N_REQ-1:0]         req_ready;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_err;
    logic                     alu_start;
    logic [5:0]               alu_op;
    logic [DATA_W-1:0]        alu_a;
    logic [DATA_W-1:0]        alu_b;
    logic [DATA_W-1:0]        alu_result;
    logic                     alu_done;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full grant with all requesters held valid; the ALU answers in the first WAIT cycle.
    task automatic serve(input int exp_id);
        tick();
        chk("rr_ready", 64'(req_ready), 64'(4'b0001 << exp_id));
        chk("rr_start", 64'(alu_start), 64'd1);
        chk("rr_a", 64'(alu_a), 64'(100 + exp_id));
        chk("rr_b", 64'(alu_b), 64'(200 + exp_id));
        tick();
        alu_done   = 1'b1;
        alu_result = 32'(exp_id * 16 + 7);
        tick();
        alu_done   = 1'b0;
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr_rsp_id", 64'(rsp_id), 64'(exp_id));
        chk("rr_rsp_data", 64'(rsp_data), 64'(exp_id * 16 + 7));
        chk("rr_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        chk("rr_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        alu_result = '0;
        alu_done   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_start", 64'(alu_start), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Single request from index 0: 30 + 18 = 48
        req_valid      = 4'b0001;
        req_op[5:0]    = 6'h01;
        req_a[31:0]    = 32'd30;
        req_b[31:0]    = 32'd18;
        tick();
        chk("s_ready", 64'(req_ready), 64'b0001);
        chk("s_start", 64'(alu_start), 64'd1);
        chk("s_busy", 64'(busy), 64'd1);
        chk("s_op", 64'(alu_op), 64'h01);
        chk("s_a", 64'(alu_a), 64'd30);
        chk("s_b", 64'(alu_b), 64'd18);
        req_valid = '0;
        tick();
        chk("s_wait_start", 64'(alu_start), 64'd0);
        chk("s_wait_ready", 64'(req_ready), 64'd0);
        chk("s_wait_rsp", 64'(rsp_valid), 64'd0);
        alu_done   = 1'b1;
        alu_result = 32'd48;
        tick();
        alu_done   = 1'b0;
        chk("s_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("s_rsp_id", 64'(rsp_id), 64'd0);
        chk("s_rsp_data", 64'(rsp_data), 64'd48);
        chk("s_rsp_err", 64'(rsp_err), 64'd0);
        chk("s_hold_a", 64'(alu_a), 64'd30);
        tick();
        chk("s_idle_busy", 64'(busy), 64'd0);
        chk("s_idle_rsp", 64'(rsp_valid), 64'd0);

        // Illegal opcode 6'h20 from index 2
        req_valid    = 4'b0100;
        req_op[17:12] = 6'h20;
        tick();
        chk("ill_ready", 64'(req_ready), 64'b0100);
        chk("ill_start", 64'(alu_start), 64'd0);
        req_valid = '0;
        tick();
        chk("ill_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("ill_rsp_id", 64'(rsp_id), 64'd2);
        chk("ill_rsp_err", 64'(rsp_err), 64'd1);
        chk("ill_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        chk("ill_idle", 64'(busy), 64'd0);

        // Timeout from index 3; a done pulse during ISSUE must be ignored
        req_valid     = 4'b1000;
        req_op[23:18] = 6'h02;
        tick();
        chk("to_ready", 64'(req_ready), 64'b1000);
        chk("to_start", 64'(alu_start), 64'd1);
        req_valid  = '0;
        alu_done   = 1'b1;
        alu_result = 32'hA5A5_A5A5;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            alu_done = 1'b0;
            chk("to_wait_rsp", 64'(rsp_valid), 64'd0);
            chk("to_wait_busy", 64'(busy), 64'd1);
        end
        tick();
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_rsp_id", 64'(rsp_id), 64'd3);
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        chk("to_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        chk("to_idle", 64'(busy), 64'd0);

        // Round robin with every requester held valid
        for (int i = 0; i < N_REQ; i++) begin
            req_op[6*i +: 6]       = 6'h03;
            req_a[DATA_W*i +: DATA_W] = 32'(100 + i);
            req_b[DATA_W*i +: DATA_W] = 32'(200 + i);
        end
        req_valid = 4'b1111;
        serve(0);
        serve(1);
        serve(2);
        serve(3);
        serve(0);
        req_valid = '0;

        // Collision: done lands on the last WAIT cycle; highest legal opcode 6'h0B
        req_valid     = 4'b0010;
        req_op[11:6]  = 6'h0B;
        req_a[63:32]  = 32'd7;
        tick();
        chk("col_ready", 64'(req_ready), 64'b0010);
        chk("col_start", 64'(alu_start), 64'd1);
        req_valid = '0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
        end
        chk("col_pre_rsp", 64'(rsp_valid), 64'd0);
        alu_done   = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        tick();
        alu_done   = 1'b0;
        chk("col_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("col_rsp_id", 64'(rsp_id), 64'd1);
        chk("col_rsp_err", 64'(rsp_err), 64'd0);
        chk("col_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        tick();

        // Reset while in WAIT
        req_valid     = 4'b0100;
        req_op[17:12] = 6'h05;
        tick();
        chk("rw_ready", 64'(req_ready), 64'b0100);
        req_valid = '0;
        tick();
        chk("rw_in_wait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_alu_op", 64'(alu_op), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 4'b1111;
        tick();
        chk("rw_first_grant", 64'(req_ready), 64'b0001);
        chk("rw_first_a", 64'(alu_a), 64'd100);
        req_valid = '0;
        tick();
        alu_done   = 1'b1;
        alu_result = 32'd1;
        tick();
        alu_done   = 1'b0;
        chk("rw_rsp_id", 64'(rsp_id), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
